// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock.
// The cipher key is expanded into an 11-entry round-key store, then rounds run from rk10 down to rk0.
// Valid/ready handshakes on both sides; only one job is in flight at a time.
module aes_inv_cipher_iter #(
    parameter int unsigned KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    localparam int unsigned NUM_RK   = 11;
    localparam int unsigned CTR_W    = 4;
    localparam int unsigned LAST_RND = 10;

    // Byte i of a block sits in element [15-i], so byte 0 is bits [127:120]
    typedef logic [15:0][7:0] blk_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEYEXP,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state_q;
    blk_t               ct_q;
    blk_t               s_q;
    logic [127:0]       rk_q [NUM_RK];
    logic               cache_valid_q;
    logic [CTR_W-1:0]   kcnt_q;
    logic [CTR_W-1:0]   rnd_q;

    logic               cache_hit_c;
    logic [127:0]       rk_rd_c;
    logic [127:0]       rk_prev_c;
    logic [127:0]       rk_new_c;
    blk_t               core_c;
    blk_t               mix_c;

    // GF(2^8) multiply by x, modulo 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply (shift-and-add)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        p = x;
        for (int i = 0; i < 6; i++) begin
            p = gf_mul(gf_mul(p, p), x);
        end
        return gf_mul(p, p);
    endfunction

    // Forward S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic blk_t inv_shift_rows(input blk_t a);
        blk_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[4'(15 - (r + 4 * c))] = a[4'(15 - (r + 4 * ((c - r + 4) % 4)))];
            end
        end
        return o;
    endfunction

    function automatic blk_t inv_sub_bytes(input blk_t a);
        blk_t o;
        for (int i = 0; i < 16; i++) begin
            o[i] = inv_sbox(a[i]);
        end
        return o;
    endfunction

    function automatic blk_t inv_mix_columns(input blk_t a);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = a[4'(15 - 4 * c)];
            a1 = a[4'(14 - 4 * c)];
            a2 = a[4'(13 - 4 * c)];
            a3 = a[4'(12 - 4 * c)];
            o[4'(15 - 4 * c)] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[4'(14 - 4 * c)] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[4'(13 - 4 * c)] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[4'(12 - 4 * c)] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [CTR_W-1:0] idx);
        logic [7:0] v;
        case (idx)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // One AES-128 key-schedule step: previous round key to the next one
    function automatic logic [127:0] expand_step(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Shared round datapath and key-schedule step
    always_comb begin
        cache_hit_c = (KEY_CACHE != 0) && cache_valid_q && (key == rk_q[0]);
        rk_rd_c     = (rnd_q <= CTR_W'(LAST_RND)) ? rk_q[rnd_q] : 128'h0;
        rk_prev_c   = (kcnt_q != '0 && kcnt_q <= CTR_W'(LAST_RND))
                      ? rk_q[CTR_W'(kcnt_q - 4'd1)] : 128'h0;
        rk_new_c    = expand_step(rk_prev_c, rcon(kcnt_q));
        core_c      = inv_sub_bytes(inv_shift_rows(s_q)) ^ blk_t'(rk_rd_c);
        mix_c       = inv_mix_columns(core_c);
    end

    // Control FSM, key store, round state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            plaintext     <= 128'h0;
            ct_q          <= '0;
            s_q           <= '0;
            cache_valid_q <= 1'b0;
            kcnt_q        <= '0;
            rnd_q         <= '0;
            for (int i = 0; i < 11; i++) begin
                rk_q[i] <= 128'h0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        ct_q     <= ciphertext;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        rnd_q    <= CTR_W'(LAST_RND);
                        if (cache_hit_c) begin
                            state_q <= S_ROUND;
                        end else begin
                            rk_q[0]       <= key;
                            cache_valid_q <= 1'b0;
                            kcnt_q        <= 4'd1;
                            state_q       <= S_KEYEXP;
                        end
                    end
                end
                S_KEYEXP: begin
                    rk_q[kcnt_q] <= rk_new_c;
                    if (kcnt_q == CTR_W'(LAST_RND)) begin
                        cache_valid_q <= 1'b1;
                        kcnt_q        <= '0;
                        state_q       <= S_ROUND;
                    end else begin
                        kcnt_q <= kcnt_q + 4'd1;
                    end
                end
                S_ROUND: begin
                    if (rnd_q == CTR_W'(LAST_RND)) begin
                        s_q   <= ct_q ^ blk_t'(rk_rd_c);
                        rnd_q <= rnd_q - 4'd1;
                    end else if (rnd_q == '0) begin
                        s_q       <= core_c;
                        plaintext <= core_c;
                        out_valid <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        s_q   <= mix_c;
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
